game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
- Produces the 2-bit screen code that drives the screen multiplexer, sequencing START -> GAME -> PLAYER_1/PLAYER_2 -> START.
- Watches the player's start button, both players' point counters and the VGA vsync as a frame tick.
- Issues a one-cycle game reset pulse on every entry into GAME, so the game drawing logic begins from a clean state.
- Sits between the input/scoring logic and the screen multiplexer, in the main clock domain.

Parameters:
WIN_POINTS, 20, point threshold for a win; legal range 1..31 (compared against 5-bit counters).
HOLD_FRAMES, 120, minimum number of frames an end screen is shown before start is accepted; must be >= 1.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  asynchronous, active-low reset (asserted at 0).
start  input  1  start button level, already synchronised to clk.
vsync  input  1  vsync from the VGA timing path; a rising edge is one frame tick.
points_p1  input  5  player 1 score, unsigned.
points_p2  input  5  player 2 score, unsigned.
screen  output  2  screen code: START=2'd0, GAME=2'd1, PLAYER_1=2'd2, PLAYER_2=2'd3.
game_rst  output  1  one-cycle active-high pulse when screen enters GAME.

Behaviour:
- Reset (rst=0, asynchronous, no clock required):
  - screen=START, game_rst=0, hold counter=0.
  - start_q=1 and vsync_q=1, so a level that is already high at reset release does not create an edge.
- Edge detect:
  - start_rise = start & ~start_q.
  - frame_tick = vsync & ~vsync_q.
  - start_q and vsync_q are registered every cycle.
- All state changes are registered. If the qualifying condition is sampled at edge N, the new screen is visible after edge N (latency 1 clk).
- START:
  - On start_rise -> GAME.
  - game_rst=1 in the same cycle screen first reads GAME, and 0 in every other cycle.
  - Nothing else is acted on.
- GAME:
  - points_p1 >= WIN_POINTS -> PLAYER_1.
  - Otherwise points_p2 >= WIN_POINTS -> PLAYER_2.
  - Tie (both reach the threshold in the same cycle): PLAYER_1 wins.
  - start is ignored.
  - Hold counter is cleared on the transition out of GAME.
- PLAYER_1 / PLAYER_2:
  - Hold counter, width $clog2(HOLD_FRAMES+1), increments on each frame_tick and saturates at HOLD_FRAMES.
  - start_rise while counter==HOLD_FRAMES -> START.
  - start_rise before saturation is dropped, not queued.
  - A start held high across saturation does not trigger; a fresh rising edge is required.
  - Points inputs are ignored.
- A frame_tick coincident with start_rise in the cycle the counter reaches HOLD_FRAMES does not satisfy the condition; the counter value before the edge is compared.
- All four 2-bit codes are legal states; no unreachable encoding exists.
- An asynchronous reset mid-operation forces START immediately and aborts any game_rst pulse or hold count.

Test Plan:
1. Hold start=1 through reset release, keep high 10 cycles -> screen stays 0. Drop start, then raise it -> screen=1 one clk later; game_rst=1 for exactly that cycle.
2. In GAME, step points_p1 0..19 -> screen stays 1. Set points_p1=20 -> screen=2 after one clk; game_rst stays 0.
3. In GAME, set points_p1=20 and points_p2=25 in the same cycle -> screen=2. Separate run with points_p2=20 only -> screen=3.
4. In PLAYER_2:
   - Press start after 50 vsync rising edges -> screen stays 3.
   - After 120 edges, press again -> screen=0.
   - Hold start high from edge 100 to 130 with no new edge -> screen stays 3.
5. In GAME, pulse start repeatedly -> no change, no game_rst. Drop rst to 0 between clock edges -> screen=0 immediately.
6. Full loop: START -> GAME (p1 wins) -> START -> GAME -> game_rst pulses once per entry, total 2 pulses. WIN_POINTS=1, HOLD_FRAMES=1 variant completes the same loop.

Source files
------------

// File: rtl/game_state_ctrl.sv
// Screen sequencer: START -> GAME -> PLAYER_1/PLAYER_2 -> START, with a one-cycle
// game reset pulse on each entry into GAME and a minimum end-screen hold in frames.
module game_state_ctrl #(
   parameter int unsigned WIN_POINTS  = 20,
   parameter int unsigned HOLD_FRAMES = 120
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       vsync,
   input  logic [4:0] points_p1,
   input  logic [4:0] points_p2,
   output logic [1:0] screen,
   output logic       game_rst
);

   localparam int unsigned     HoldW   = $clog2(HOLD_FRAMES + 1);
   localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_FRAMES);
   localparam logic [4:0]       WinPts  = 5'(WIN_POINTS);

   typedef enum logic [1:0] {
      StStart   = 2'd0,
      StGame    = 2'd1,
      StPlayer1 = 2'd2,
      StPlayer2 = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             game_rst_q, game_rst_d;
   logic             start_q, vsync_q;
   logic             start_rise, frame_tick;

   assign start_rise = start & ~start_q;
   assign frame_tick = vsync & ~vsync_q;

   // Edge history resets high so a level already asserted at release is not an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StStart;
         hold_q     <= '0;
         game_rst_q <= 1'b0;
         start_q    <= 1'b1;
         vsync_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         game_rst_q <= game_rst_d;
         start_q    <= start;
         vsync_q    <= vsync;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      game_rst_d = 1'b0;
      unique case (state_q)
         StStart: begin
            if (start_rise) begin
               state_d    = StGame;
               game_rst_d = 1'b1;
            end
         end
         StGame: begin
            hold_d = '0;
            if (points_p1 >= WinPts) begin
               state_d = StPlayer1;
            end else if (points_p2 >= WinPts) begin
               state_d = StPlayer2;
            end
         end
         StPlayer1, StPlayer2: begin
            // Compare the pre-edge count so a coincident tick cannot unlock this press.
            if (start_rise && (hold_q == HoldMax)) begin
               state_d = StStart;
               hold_d  = '0;
            end else if (frame_tick && (hold_q != HoldMax)) begin
               hold_d = hold_q + HoldW'(1);
            end
         end
      endcase
   end

   always_comb begin
      screen   = state_q;
      game_rst = game_rst_q;
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: directed sequences, a vector table and random stimulus,
// with a frame-counting reference model for the default and the minimal parameter sets.
module tb_game_state_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       vsync;
   logic [4:0] p1;
   logic [4:0] p2;
   logic [1:0] scr_b, scr_s;
   logic       grst_b, grst_s;

   int n_cmp  = 0;
   int n_fail = 0;
   int pulses_b = 0;
   int pulses_s = 0;

   game_state_ctrl u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .vsync     (vsync),
      .points_p1 (p1),
      .points_p2 (p2),
      .screen    (scr_b),
      .game_rst  (grst_b)
   );

   game_state_ctrl #(
      .WIN_POINTS  (1),
      .HOLD_FRAMES (1)
   ) u_small (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .vsync     (vsync),
      .points_p1 (p1),
      .points_p2 (p2),
      .screen    (scr_s),
      .game_rst  (grst_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: screen number plus an unbounded count of frames since the
   // end screen was entered; a press counts once at least `hold` frames have passed.
   typedef struct {
      int scr;
      int frames;
      bit ps;
      bit pv;
      bit grst;
   } mstate_t;

   mstate_t m_b, m_s;

   function automatic mstate_t m_init();
      mstate_t n;
      n.scr = 0; n.frames = 0; n.ps = 1'b1; n.pv = 1'b1; n.grst = 1'b0;
      return n;
   endfunction

   function automatic mstate_t step(mstate_t m, int win, int hold, bit s, bit v,
                                    int a, int b);
      mstate_t n;
      bit rise;
      bit tick;
      n = m;
      rise = s && !m.ps;
      tick = v && !m.pv;
      n.ps = s;
      n.pv = v;
      n.grst = 1'b0;
      case (m.scr)
         0: if (rise) begin n.scr = 1; n.grst = 1'b1; end
         1: begin
            if (a >= win) begin n.scr = 2; n.frames = 0; end
            else if (b >= win) begin n.scr = 3; n.frames = 0; end
         end
         default: begin
            if (rise && m.frames >= hold) n.scr = 0;
            if (tick) n.frames = m.frames + 1;
         end
      endcase
      return n;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_b <= m_init();
         m_s <= m_init();
      end else begin
         m_b <= step(m_b, 20, 120, start, vsync, int'(p1), int'(p2));
         m_s <= step(m_s, 1, 1, start, vsync, int'(p1), int'(p2));
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      check("model_screen_big", int'(scr_b), m_b.scr);
      check("model_grst_big", int'(grst_b), int'(m_b.grst));
      check("model_screen_small", int'(scr_s), m_s.scr);
      check("model_grst_small", int'(grst_s), int'(m_s.grst));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         chk_model();
         if (grst_b) pulses_b++;
         if (grst_s) pulses_s++;
      end
   endtask

   // Asserts reset between clock edges and checks the outputs respond without a clock.
   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      check("async_rst_screen", int'(scr_b), 0);
      check("async_rst_grst", int'(grst_b), 0);
      check("async_rst_screen_small", int'(scr_s), 0);
      #4 rst = 1'b1;
      pulses_b = 0;
      pulses_s = 0;
      cyc(1);
   endtask

   task automatic press();
      start = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         vsync = 1'b1;
         cyc(1);
         vsync = 1'b0;
         cyc(1);
      end
   endtask

   typedef struct {
      logic [4:0] a;
      logic [4:0] b;
      int         exp;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{a: 5'd0,  b: 5'd0,  exp: 1};
      tbl[1] = '{a: 5'd19, b: 5'd19, exp: 1};
      tbl[2] = '{a: 5'd20, b: 5'd0,  exp: 2};
      tbl[3] = '{a: 5'd0,  b: 5'd20, exp: 3};
      tbl[4] = '{a: 5'd20, b: 5'd25, exp: 2};
      tbl[5] = '{a: 5'd31, b: 5'd31, exp: 2};
      tbl[6] = '{a: 5'd19, b: 5'd31, exp: 3};
      tbl[7] = '{a: 5'd31, b: 5'd0,  exp: 2};

      rst = 1'b0;
      start = 1'b1;
      vsync = 1'b0;
      p1 = '0;
      p2 = '0;

      // Start held high through reset release must not count as a press.
      cyc(3);
      #2 rst = 1'b1;
      cyc(10);
      check("t1_held_start", int'(scr_b), 0);
      start = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
      check("t1_enter_game", int'(scr_b), 1);
      check("t1_grst_pulse", int'(grst_b), 1);
      cyc(1);
      check("t1_grst_clear", int'(grst_b), 0);

      // Points below threshold keep GAME; reaching it selects PLAYER_1.
      do_reset();
      press();
      for (int i = 0; i < 20; i++) begin
         p1 = 5'(i);
         cyc(1);
         check("t2_below_win", int'(scr_b), 1);
      end
      p1 = 5'd20;
      cyc(1);
      check("t2_p1_wins", int'(scr_b), 2);
      check("t2_no_grst", int'(grst_b), 0);
      p1 = '0;

      for (int i = 0; i < 8; i++) begin
         start = 1'b0;
         do_reset();
         press();
         p1 = tbl[i].a;
         p2 = tbl[i].b;
         cyc(1);
         check("tbl_screen", int'(scr_b), tbl[i].exp);
         p1 = '0;
         p2 = '0;
      end

      // End-screen hold: early presses dropped, held level across saturation ignored.
      start = 1'b0;
      do_reset();
      press();
      p2 = 5'd20;
      cyc(1);
      check("t4_p2_wins", int'(scr_b), 3);
      p2 = '0;
      start = 1'b0;
      cyc(1);
      frames(50);
      start = 1'b1;
      cyc(1);
      check("t4_early_press", int'(scr_b), 3);
      start = 1'b0;
      cyc(1);
      frames(50);
      start = 1'b1;
      frames(30);
      check("t4_held_across_sat", int'(scr_b), 3);
      start = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
      check("t4_fresh_press", int'(scr_b), 0);

      // Tick and press in the same cycle that saturates the count: not accepted.
      start = 1'b0;
      do_reset();
      press();
      p1 = 5'd20;
      cyc(1);
      p1 = '0;
      start = 1'b0;
      frames(119);
      vsync = 1'b1;
      start = 1'b1;
      cyc(1);
      check("coincident_tick_press", int'(scr_b), 2);
      vsync = 1'b0;
      start = 1'b0;
      cyc(1);
      start = 1'b1;
      cyc(1);
      check("press_after_sat", int'(scr_b), 0);

      // Start ignored in GAME; reset aborts a pending pulse.
      start = 1'b0;
      do_reset();
      press();
      for (int i = 0; i < 4; i++) begin
         start = 1'b0;
         cyc(1);
         start = 1'b1;
         cyc(1);
         check("t5_game_ignores_start", int'(scr_b), 1);
         check("t5_no_extra_grst", int'(grst_b), 0);
      end
      start = 1'b0;
      do_reset();
      press();
      check("t5_pulse_before_abort", int'(grst_b), 1);
      do_reset();

      // Full loop twice through GAME; both parameter sets see two pulses.
      start = 1'b0;
      do_reset();
      press();
      p1 = 5'd20;
      cyc(1);
      check("t6_p1_wins", int'(scr_b), 2);
      p1 = '0;
      start = 1'b0;
      frames(120);
      press();
      check("t6_back_to_start", int'(scr_b), 0);
      press();
      check("t6_game_again", int'(scr_b), 1);
      check("t6_pulses_big", pulses_b, 2);
      check("t6_screen_small", int'(scr_s), 1);
      check("t6_pulses_small", pulses_s, 2);

      // Random stimulus against the model.
      start = 1'b0;
      do_reset();
      for (int i = 0; i < 5000; i++) begin
         if ($urandom_range(0, 7) == 0) start = ~start;
         vsync = 1'($urandom_range(0, 1));
         p1 = ($urandom_range(0, 63) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(0, 15));
         p2 = ($urandom_range(0, 63) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(0, 15));
         cyc(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
